// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: WIDTH-bit add/subtract rippling one CHUNK per stage, with
// valid/ready handshake, carry/overflow/zero flags and a sticky clearable overflow flag.
module pipelined_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    input  logic             clr_exc,
    output logic             exc_sticky
);
    localparam int N = WIDTH / CHUNK;

    logic w_en;
    logic r_ovf, r_zero, r_exc;

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad
        $fatal(1, "pipelined_adder_sub: WIDTH must be a positive multiple of CHUNK");
    end

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Stage g keeps only the operand bits still to be summed and the sum bits already done.
    for (genvar g = 0; g < N; g++) begin : stg
        localparam int RW = WIDTH - g * CHUNK;
        logic                   w_v, w_c;
        logic [RW-1:0]          w_a, w_b;
        logic [CHUNK:0]         w_t;
        logic [(g+1)*CHUNK-1:0] w_s;
        logic                   r_v, r_c;
        logic [(g+1)*CHUNK-1:0] r_s;
        if (g == 0) begin : src
            assign w_v = in_valid;
            assign w_c = sub | cin;
            assign w_a = inp1;
            assign w_b = sub ? ~inp2 : inp2;
            assign w_s = w_t[CHUNK-1:0];
        end else begin : chain
            assign w_v = stg[g-1].r_v;
            assign w_c = stg[g-1].r_c;
            assign w_a = stg[g-1].mid.r_a;
            assign w_b = stg[g-1].mid.r_b;
            assign w_s = {w_t[CHUNK-1:0], stg[g-1].r_s};
        end
        assign w_t = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_c};
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v;
                if (w_v) begin
                    r_c <= w_t[CHUNK];
                    r_s <= w_s;
                end
            end
        end
        if (g < N - 1) begin : mid
            logic [RW-CHUNK-1:0] r_a, r_b;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en && w_v) begin
                    r_a <= w_a[RW-1:CHUNK];
                    r_b <= w_b[RW-1:CHUNK];
                end
            end
        end
    end

    // The last stage still sees the operand MSBs, so the flags are registered alongside its sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en && stg[N-1].w_v) begin
            r_ovf  <= (stg[N-1].w_a[CHUNK-1] == stg[N-1].w_b[CHUNK-1]) &&
                      (stg[N-1].w_s[WIDTH-1] != stg[N-1].w_a[CHUNK-1]);
            r_zero <= stg[N-1].w_s == '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_exc <= 1'b0;
        else if (out_valid && out_ready && r_ovf) r_exc <= 1'b1;
        else if (clr_exc) r_exc <= 1'b0;
    end

    assign out_valid  = stg[N-1].r_v;
    assign sum        = stg[N-1].r_s;
    assign cout       = stg[N-1].r_c;
    assign ovf        = r_ovf;
    assign zero       = r_zero;
    assign exc_sticky = r_exc;
endmodule
